// File: rtl/uart_rx_buffer_if.sv
// Byte-receiver input and head-of-FIFO output stream for the UART receive buffer.
// The master drives received bytes and out_ready; the slave presents the buffered stream.
interface uart_rx_buffer_if;
    logic [7:0] rx_byte;
    logic       rx_done;
    logic       rx_parity_error;
    logic [7:0] out_data;
    logic       out_perr;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output rx_byte, rx_done, rx_parity_error, out_ready,
        input  out_data, out_perr, out_valid
    );

    modport slave (
        input  rx_byte, rx_done, rx_parity_error, out_ready,
        output out_data, out_perr, out_valid
    );
endinterface

// File: rtl/uart_rx_buffer.sv
// UART receive buffer: first-word fall-through FIFO of {perr, byte} with overflow/parity stats and idle-gap pulse.
// Push is lost (counted) only when full with no same-cycle pop; out_valid/out_ready drains the head.
module uart_rx_buffer #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_rx_buffer_if.slave  bus,
    input  logic             drop_bad,
    input  logic [23:0]      idle_cycles,
    input  logic             clear,
    output logic [AW:0]      level,
    output logic             overflow,
    output logic [7:0]       drop_count,
    output logic [7:0]       perr_count,
    output logic             idle_pulse
);

    logic [8:0]  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] level_q, level_d;
    logic        overflow_q, overflow_d;
    logic [7:0]  drop_count_q, drop_count_d;
    logic [7:0]  perr_count_q, perr_count_d;
    logic [23:0] timer_q, timer_d;
    logic        armed_q, armed_d;

    logic empty, full, pop, push_req, push, lost, idle_hit;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    assign pop      = !empty && bus.out_ready;
    // Parity-bad bytes discarded under drop_bad never count as overflow losses.
    assign push_req = bus.rx_done && !(drop_bad && bus.rx_parity_error);
    assign push     = push_req && (!full || pop);
    assign lost     = push_req && full && !pop;

    assign idle_hit = armed_q && (idle_cycles != 24'd0) && (timer_q == idle_cycles)
                      && !bus.rx_done && !clear;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        perr_count_d = perr_count_q;
        timer_d      = timer_q;
        armed_d      = armed_q;
        if (clear) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            level_d      = '0;
            overflow_d   = 1'b0;
            drop_count_d = '0;
            perr_count_d = '0;
            timer_d      = '0;
            armed_d      = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
            if (lost) begin
                overflow_d = 1'b1;
                if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
            end
            if (bus.rx_done && bus.rx_parity_error && perr_count_q != 8'hFF)
                perr_count_d = perr_count_q + 8'd1;
            if (bus.rx_done) begin
                armed_d = 1'b1;
                timer_d = 24'd1;
            end else if (armed_q) begin
                if (idle_hit || idle_cycles == 24'd0) armed_d = 1'b0;
                else                                  timer_d = timer_q + 24'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
            perr_count_q <= '0;
            timer_q      <= '0;
            armed_q      <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
            perr_count_q <= perr_count_d;
            timer_q      <= timer_d;
            armed_q      <= armed_d;
        end
    end

    // Storage carries no reset; out_data is only meaningful while out_valid is high.
    always_ff @(posedge clk) begin
        if (push && !clear)
            mem_q[wr_ptr_q[AW-1:0]] <= {bus.rx_parity_error, bus.rx_byte};
    end

    assign bus.out_valid = !empty;
    assign bus.out_data  = mem_q[rd_ptr_q[AW-1:0]][7:0];
    assign bus.out_perr  = mem_q[rd_ptr_q[AW-1:0]][8];

    assign level      = level_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;
    assign perr_count = perr_count_q;
    assign idle_pulse = idle_hit;

endmodule

// File: doc/uart_rx_buffer.md
Name: uart_rx_buffer

Overview:
Receive-side counterpart to the UART TX FIFO path. Sits between the byte-level UART receiver and the USB-CDC upstream logic.
- Buffers received bytes and their parity-error flags in a FIFO.
- Presents them on a valid/ready stream.
- Keeps overflow and parity statistics.
- Flags an idle gap on the line so upstream can flush a partial USB packet.

Parameters:
DEPTH, 32, FIFO entries; power of two, at least 2.
AW, 5, log2(DEPTH); pointer index width.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
rx_byte  input  8  received byte from the byte receiver; valid only while rx_done is high
rx_done  input  1  one-cycle strobe: rx_byte and rx_parity_error are valid
rx_parity_error  input  1  parity error for the current byte, qualified by rx_done
drop_bad  input  1  1 = bytes with a parity error are discarded rather than stored
idle_cycles  input  24  idle gap length in clk cycles; 0 disables idle detection
clear  input  1  synchronous flush of FIFO, flags, counters and idle timer
out_data  output  8  head-of-FIFO byte
out_perr  output  1  parity-error flag of the head byte
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer accepts the head byte when out_valid is also high
level  output  AW+1  current FIFO occupancy, 0..DEPTH
overflow  output  1  sticky: at least one byte was lost because the FIFO was full
drop_count  output  8  bytes lost to overflow, saturating at 255
perr_count  output  8  rx_done strobes with rx_parity_error set, saturating at 255
idle_pulse  output  1  one-cycle pulse at the end of an idle gap

Behaviour:
Reset (async, rst_n low):
- Pointers 0, level 0, out_valid 0.
- overflow 0, drop_count 0, perr_count 0, idle_pulse 0, idle timer disarmed.
- FIFO storage is not reset; out_data and out_perr are don't-care while out_valid is 0.
- Reset mid-stream discards all buffered bytes.

Storage:
- Entries are 9 bits: {perr, data}.
- Pointers are AW+1 bits with a wrap bit.
- empty when pointers are fully equal; full when the index bits are equal and the wrap bits differ.
- Index wraps DEPTH-1 -> 0.

Push:
- A push is requested on rx_done.
- If drop_bad=1 and rx_parity_error=1, the byte is discarded silently: no overflow, no drop_count change.
- Otherwise it is stored if not full, or if a pop occurs in the same cycle.
- Push while full with no pop: byte discarded, overflow set, drop_count +1 (saturating).

Pop:
- Occurs when out_valid && out_ready.
- The read pointer advances at the clock edge.

Simultaneous push and pop:
- Both take effect; level is unchanged.
- Applies at full and at every other level. At empty a pop is impossible since out_valid is 0.

Latency:
- A byte pushed on edge N shows out_valid=1 with out_data and out_perr valid after edge N (first-word fall-through).
- out_data and out_perr are a combinational read of the head entry.

level:
- Registered; updates on the same edge as the pointers.

perr_count:
- Increments on every rx_done with rx_parity_error=1, regardless of drop_bad or full.

Idle detector:
- Timer is a 24-bit counter plus an armed flag.
- rx_done sets armed=1 and loads counter=1.
- While armed and no rx_done, counter increments each cycle.
- When armed and counter == idle_cycles: idle_pulse=1 for that cycle, armed cleared.
- A new rx_done in any cycle restarts the gap; it takes priority over pulse generation.
- idle_cycles=0 keeps armed cleared and idle_pulse=0.
- Changing idle_cycles while armed compares against the new value immediately.

clear:
- Highest priority over push, pop and timer in the same cycle.
- Next state: pointers 0, level 0, out_valid 0, overflow 0, both counters 0, armed 0, idle_pulse 0.
- A push or pop coincident with clear is discarded.

Test Plan:
- Reset, then push 0x41,0x42,0x43 with out_ready=0 -> level=3, out_valid=1, out_data=0x41; raise out_ready for 3 cycles -> 0x41,0x42,0x43 in order, level returns to 0, out_valid=0.
- Push 34 bytes 0x00..0x21 with out_ready=0 -> level=32, overflow=1, drop_count=2; drain yields exactly 0x00..0x1F.
- Fill to 32, then push 0x55 in the same cycle as a pop -> level stays 32; 0x55 emerges 32nd in the drain; overflow stays 0.
- drop_bad=1: push 0x10 (perr=0), 0x11 (perr=1), 0x12 (perr=0) -> FIFO holds 0x10,0x12, perr_count=1; repeat with drop_bad=0 -> 0x11 stored with out_perr=1, perr_count=2.
- idle_cycles=100: rx_done at cycle 0 -> idle_pulse high exactly at cycle 100, single cycle; second run with rx_done at cycle 0 and 50 -> pulse only at cycle 150; idle_cycles=0 -> no pulse.
- With level=5, overflow=1, counters nonzero: assert clear together with rx_done -> next cycle everything is zero, out_valid=0, the coincident byte is not stored; async rst_n low mid-drain -> outputs return to reset values immediately.
